serial_sub_flags: RTL and testbench
===================================

Name: serial_sub_flags

Overview:
Multi-cycle signed/unsigned subtractor that computes a − b over WIDTH bits, CHUNK bits per cycle, LSB chunk first.
It produces the condition flags consumed by the set-less-than and branch logic: msb, overflow, carry_out and zero.
It sits between the operand register stage and the SLT/flag consumers.
Valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, operand and result width in bits
CHUNK, 8, bits processed per cycle; must divide WIDTH (NUM_CHUNKS = WIDTH/CHUNK ≥ 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands a, b presented
in_ready  out  1  block can accept operands
a  in  WIDTH  minuend
b  in  WIDTH  subtrahend
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
diff  out  WIDTH  a − b, modulo 2^WIDTH
msb  out  1  diff[WIDTH-1]
overflow  out  1  signed overflow of a − b
carry_out  out  1  carry out of a + ~b + 1; 1 = no unsigned borrow (a ≥ b unsigned)
zero  out  1  diff == 0

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: rst_n low at a clk edge forces IDLE.
  - in_ready=1 out of reset; out_valid=0; diff=0; msb, overflow, carry_out, zero = 0.
  - Reset mid-RUN or mid-DONE abandons the operation; no result is ever presented for it.
- IDLE: in_ready=1.
  - On in_valid && in_ready: latch a, b; carry register := 1; chunk counter := 0; go to RUN.
- RUN: in_ready=0, out_valid=0.
  - Each cycle, add chunk k of a, chunk k of ~b and the carry register.
  - Shift the CHUNK-bit sum into diff from the top (right shift), so after NUM_CHUNKS cycles diff is in order.
  - Update the carry register; increment the counter.
  - Operands are held internally; a and b inputs are ignored after acceptance.
- Last chunk (counter == NUM_CHUNKS−1):
  - carry_out := final carry.
  - overflow := carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
  - msb := diff[WIDTH−1]; zero := (complete diff == 0).
  - Go to DONE.
- DONE: out_valid=1; all outputs stable until handshake.
  - On out_ready: go to IDLE, drop out_valid.
  - Outputs keep their last values after the handshake; only out_valid qualifies them.
- Latency: acceptance edge at cycle 0 → out_valid high after edge NUM_CHUNKS (32/8 → 4 cycles).
  - Minimum spacing between accepts is NUM_CHUNKS+2 cycles.
  - No input accept while in DONE, even if out_ready is high in the same cycle.
- out_ready high while not in DONE is ignored.
- in_valid while in RUN/DONE: not accepted; the source must hold a, b until in_ready.
- CHUNK == WIDTH is legal: single RUN cycle.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE, RUN, DONE)
  - localparam function for NUM_CHUNKS
  - counter width as $clog2(NUM_CHUNKS)+1
- One combinational sub-module, sub_chunk:
  - inputs: CHUNK-bit x, CHUNK-bit y_inv, cin
  - outputs: sum, cout, c_msb (carry into the top bit of the slice)
  - The top-level uses c_msb from the final chunk for overflow.
- FSM, counter and shift register stay in the top level.

Test Plan:
- a=5, b=3 → after 4 cycles diff=0x00000002, msb=0, overflow=0, carry_out=1, zero=0.
- a=3, b=5 → diff=0xFFFFFFFE, msb=1, overflow=0, carry_out=0, zero=0.
- a=0x80000000, b=0x00000001 → diff=0x7FFFFFFF, msb=0, overflow=1 (msb^overflow=1, signed less-than true).
- a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, msb=1, overflow=1, carry_out=0; then a=b=0x1234ABCD → diff=0, zero=1, carry_out=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs unchanged, in_ready=0 throughout.
  - Change in_valid, a and b during this window → no accept and no effect on the result.
- rst_n low for 1 cycle during RUN chunk 2 → next cycle IDLE, in_ready=1, out_valid=0, flags=0.
  - Then 5−3 completes with correct diff=2.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the chunked serial subtractor.
package serial_sub_pkg;

    // Controller states: waiting for operands, stepping chunks, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices in a WIDTH-wide operand.
    function automatic int calc_num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter wide enough to hold 0 .. num_chunks.
    function automatic int calc_cnt_width(input int num_chunks);
        return $clog2(num_chunks) + 1;
    endfunction

endpackage

// File: rtl/serial_sub_flags_sub_chunk.sv
// One CHUNK-wide slice of x + y_inv + cin. Besides the carry out it reports
// the carry into the slice's top bit, which the caller needs for signed overflow.
module sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y_inv,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    assign full  = {1'b0, x} + {1'b0, y_inv} + {{CHUNK{1'b0}}, cin};
    assign sum   = full[CHUNK-1:0];
    assign cout  = full[CHUNK];
    // The sum bit is x ^ y ^ carry_in, so the carry into the top bit falls out by XOR.
    assign c_msb = x[CHUNK-1] ^ y_inv[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/serial_sub_flags.sv
// Multi-cycle a - b computed as a + ~b + 1, CHUNK bits per cycle, LSB chunk
// first, producing diff plus msb / overflow / carry_out / zero for SLT and
// branch consumers.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// where diff and all flags are frozen until out_ready completes the transfer.
// After that the outputs keep their values but are qualified only by out_valid.
module serial_sub_flags
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             msb,
    output logic             overflow,
    output logic             carry_out,
    output logic             zero
);

    localparam int NUM_CHUNKS = calc_num_chunks(WIDTH, CHUNK);
    localparam int CW         = calc_cnt_width(NUM_CHUNKS);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_CHUNKS - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             c_msb;
    logic [WIDTH-1:0] acc_next;

    // Operands are shifted right each RUN cycle, so the current chunk is always the low slice.
    sub_chunk #(
        .CHUNK (CHUNK)
    ) u_sub_chunk (
        .x     (a_q[CHUNK-1:0]),
        .y_inv (~b_q[CHUNK-1:0]),
        .cin   (carry_q),
        .sum   (sum),
        .cout  (cout),
        .c_msb (c_msb)
    );

    // New slice enters at the top; after NUM_CHUNKS steps the result is in order.
    assign acc_next = (acc >> CHUNK) | (WIDTH'(sum) << (WIDTH - CHUNK));

    // Controller, chunk datapath and registered result/flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            msb       <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry_q  <= 1'b1;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    acc     <= acc_next;
                    carry_q <= cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        diff      <= acc_next;
                        msb       <= acc_next[WIDTH-1];
                        overflow  <= c_msb ^ cout;
                        carry_out <= cout;
                        zero      <= (acc_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_flags.sv
// Bench for serial_sub_flags: directed subtraction vectors with hand-computed
// results, backpressure hold, and reset in the middle of an operation.
module tb_serial_sub_flags;

    localparam int WIDTH      = 32;
    localparam int CHUNK      = 8;
    localparam int NUM_CHUNKS = 4;
    localparam int EW         = WIDTH + 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             msb;
    logic             overflow;
    logic             carry_out;
    logic             zero;

    int tests = 0;
    int fails = 0;

    // expected word: {diff, msb, overflow, carry_out, zero}
    logic [EW-1:0] exp_q[$];

    serial_sub_flags #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .msb       (msb),
        .overflow  (overflow),
        .carry_out (carry_out),
        .zero      (zero)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // monitor: compare every delivered result against the scoreboard
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got %h, expected no result",
                         {diff, msb, overflow, carry_out, zero});
            end else begin
                check("result", 64'({diff, msb, overflow, carry_out, zero}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    // driver: present operands, push expectation on the accepting edge
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [EW-1:0] e);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // wait for out_valid, check latency, then let the handshake drain if out_ready is high
    task automatic wait_done(input int exp_lat);
        int n;
        int m;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 40);
        check("latency", 64'(n), 64'(exp_lat));
        if (out_ready) begin
            m = 0;
            while (out_valid && m < 40) begin
                @(posedge clk);
                #1;
                m++;
            end
            check("valid_drop", 64'(out_valid), 64'(0));
        end
    endtask

    logic [WIDTH-1:0] va [10];
    logic [WIDTH-1:0] vb [10];
    logic [EW-1:0]    ve [10];
    logic [EW-1:0]    bp_exp;
    logic [EW-1:0]    five_three;
    logic             saw_valid;

    initial begin
        va[0] = 32'h0000_0005; vb[0] = 32'h0000_0003; ve[0] = {32'h0000_0002, 4'b0010};
        va[1] = 32'h0000_0003; vb[1] = 32'h0000_0005; ve[1] = {32'hFFFF_FFFE, 4'b1000};
        va[2] = 32'h8000_0000; vb[2] = 32'h0000_0001; ve[2] = {32'h7FFF_FFFF, 4'b0110};
        va[3] = 32'h7FFF_FFFF; vb[3] = 32'hFFFF_FFFF; ve[3] = {32'h8000_0000, 4'b1100};
        va[4] = 32'h1234_ABCD; vb[4] = 32'h1234_ABCD; ve[4] = {32'h0000_0000, 4'b0011};
        va[5] = 32'h0000_0000; vb[5] = 32'h0000_0000; ve[5] = {32'h0000_0000, 4'b0011};
        va[6] = 32'h0000_0000; vb[6] = 32'h0000_0001; ve[6] = {32'hFFFF_FFFF, 4'b1000};
        va[7] = 32'h0000_0000; vb[7] = 32'h8000_0000; ve[7] = {32'h8000_0000, 4'b1100};
        va[8] = 32'hFFFF_FFFF; vb[8] = 32'h7FFF_FFFF; ve[8] = {32'h8000_0000, 4'b1010};
        va[9] = 32'h0001_0000; vb[9] = 32'h0000_0001; ve[9] = {32'h0000_FFFF, 4'b0010};
        bp_exp     = {32'hFFFF_FFFE, 4'b1000};
        five_three = {32'h0000_0002, 4'b0010};

        // reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'({diff, msb, overflow, carry_out, zero}), 64'(0));

        // directed vectors, consumer always ready
        for (int i = 0; i < 10; i++) begin
            send(va[i], vb[i], ve[i]);
            wait_done(NUM_CHUNKS);
        end

        // backpressure: hold DONE for 10 cycles while the source wiggles its inputs
        out_ready = 1'b0;
        send(32'h0000_0003, 32'h0000_0005, bp_exp);
        wait_done(NUM_CHUNKS);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #1;
            check("hold_result", 64'({diff, msb, overflow, carry_out, zero}), 64'(bp_exp));
            check("hold_in_ready", 64'(in_ready), 64'(0));
            check("hold_out_valid", 64'(out_valid), 64'(1));
        end
        // out_ready and in_valid together in DONE: only the output transfer happens
        a = 32'h0000_0000;
        b = 32'h0000_0001;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("done_no_accept_in_ready", 64'(in_ready), 64'(1));
        check("done_release_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        exp_q.push_back({32'hFFFF_FFFF, 4'b1000});
        #1;
        in_valid = 1'b0;
        check("accept_after_done", 64'(in_ready), 64'(0));
        wait_done(NUM_CHUNKS);

        // reset while chunk 2 is being processed
        send(32'h0000_0005, 32'h0000_0003, five_three);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_reset_in_ready", 64'(in_ready), 64'(1));
        check("midrun_reset_out_valid", 64'(out_valid), 64'(0));
        check("midrun_reset_result", 64'({diff, msb, overflow, carry_out, zero}), 64'(0));
        exp_q.delete();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("abandoned_no_result", 64'(saw_valid), 64'(0));
        send(32'h0000_0005, 32'h0000_0003, five_three);
        wait_done(NUM_CHUNKS);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
